// File: rtl/snake_pkg.sv
// Shared types and width helpers for the snake game core.
package snake_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDead = 2'd2
    } game_state_e;

    localparam logic [3:0] DIR_UP    = 4'b0001;
    localparam logic [3:0] DIR_DOWN  = 4'b0010;
    localparam logic [3:0] DIR_LEFT  = 4'b0100;
    localparam logic [3:0] DIR_RIGHT = 4'b1000;

    // Swaps UP<->DOWN and LEFT<->RIGHT.
    function automatic logic [3:0] opposite_dir(input logic [3:0] d);
        return {d[2], d[3], d[0], d[1]};
    endfunction

    function automatic int unsigned cell_width(input int unsigned w, input int unsigned h);
        return $clog2(w) + $clog2(h);
    endfunction

    function automatic int unsigned len_width(input int unsigned max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/snake_tick_gen.sv
// Free-running step timer; emits one tick every TICK_CYCLES enabled cycles.
module snake_tick_gen #(
    parameter int unsigned TICK_CYCLES = 10000000
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CNTW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    logic [CNTW-1:0] cnt_q;

    assign tick = enable && (cnt_q == CNTW'(TICK_CYCLES - 1));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q <= '0;
        end else if (clear || tick) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/snake_engine.sv
// Snake game core: body shift register, growth, collision and edge handling,
// plus a registered occupancy map for the matrix scanner.
module snake_engine
    import snake_pkg::*;
#(
    parameter int unsigned GRID_W      = 8,
    parameter int unsigned GRID_H      = 8,
    parameter int unsigned MAX_LEN     = 8,
    parameter int unsigned INIT_LEN    = 4,
    parameter int unsigned TICK_CYCLES = 10000000,
    parameter int unsigned WRAP        = 1,
    localparam int unsigned CW         = cell_width(GRID_W, GRID_H),
    localparam int unsigned LW         = len_width(MAX_LEN)
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_n,
    input  logic [3:0]              dir_req,
    input  logic                    start,
    input  logic [CW-1:0]           food_pos,
    input  logic                    food_valid,
    output logic [MAX_LEN*CW-1:0]   body,
    output logic [LW-1:0]           len,
    output logic [GRID_W*GRID_H-1:0] occ,
    output logic [1:0]              game_state,
    output logic                    step,
    output logic                    eat,
    output logic                    die
);

    localparam int unsigned XW    = $clog2(GRID_W);
    localparam int unsigned YW    = $clog2(GRID_H);
    localparam int unsigned NCELL = GRID_W * GRID_H;

    function automatic logic [MAX_LEN*CW-1:0] init_body();
        logic [MAX_LEN*CW-1:0] b;
        b = '0;
        for (int i = 0; i < INIT_LEN; i++) begin
            b[i*CW +: CW] = {YW'(GRID_H / 2), XW'(GRID_W / 2 + i)};
        end
        return b;
    endfunction

    function automatic logic [NCELL-1:0] decode_occ(input logic [MAX_LEN*CW-1:0] b,
                                                    input logic [LW-1:0] l);
        logic [NCELL-1:0] o;
        o = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (LW'(i) < l) o[b[i*CW +: CW]] = 1'b1;
        end
        return o;
    endfunction

    localparam logic [MAX_LEN*CW-1:0] INIT_BODY = init_body();
    localparam logic [NCELL-1:0]      INIT_OCC  = decode_occ(INIT_BODY, LW'(INIT_LEN));

    game_state_e           state_q, state_d;
    logic [MAX_LEN*CW-1:0] body_q, body_d;
    logic [LW-1:0]         len_q, len_d;
    logic [NCELL-1:0]      occ_q, occ_d;
    logic [3:0]            cur_q, cur_d, pend_q, pend_d;
    logic                  step_q, step_d, eat_q, eat_d, die_q, die_d;

    logic          running, tick;
    logic [XW-1:0] hx, nx;
    logic [YW-1:0] hy, ny;
    logic [CW-1:0] nh;
    logic          at_edge, wall, eat_hit, grow, collide;

    assign running = (state_q == StRun);

    snake_tick_gen #(
        .TICK_CYCLES(TICK_CYCLES)
    ) u_tick (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .enable   (running),
        .clear    (!running),
        .tick     (tick)
    );

    assign hx = body_q[XW-1:0];
    assign hy = body_q[CW-1:XW];

    always_comb begin
        nx      = hx;
        ny      = hy;
        at_edge = 1'b0;
        unique case (1'b1)
            pend_q[0]: begin ny = hy - 1'b1; at_edge = (hy == '0); end
            pend_q[1]: begin ny = hy + 1'b1; at_edge = (hy == YW'(GRID_H - 1)); end
            pend_q[2]: begin nx = hx - 1'b1; at_edge = (hx == '0); end
            pend_q[3]: begin nx = hx + 1'b1; at_edge = (hx == XW'(GRID_W - 1)); end
            default: ;
        endcase
    end

    assign nh      = {ny, nx};
    assign wall    = (WRAP == 0) && at_edge;
    assign eat_hit = food_valid && (nh == food_pos);
    assign grow    = eat_hit && (len_q < LW'(MAX_LEN));

    // The tail slot is free this step unless the snake grows.
    always_comb begin
        collide = 1'b0;
        for (int j = 0; j < MAX_LEN; j++) begin
            if ((body_q[j*CW +: CW] == nh) && (LW'(j) < len_q) &&
                !((LW'(j) == len_q - 1'b1) && !grow)) begin
                collide = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        body_d  = body_q;
        len_d   = len_q;
        cur_d   = cur_q;
        pend_d  = pend_q;
        step_d  = 1'b0;
        eat_d   = 1'b0;
        die_d   = 1'b0;

        if ($onehot(dir_req) && (dir_req != opposite_dir(cur_q))) pend_d = dir_req;

        unique case (state_q)
            StIdle: begin
                if (start) state_d = StRun;
            end
            StRun: begin
                if (tick) begin
                    if (wall || collide) begin
                        state_d = StDead;
                        die_d   = 1'b1;
                    end else begin
                        body_d = {body_q[(MAX_LEN-1)*CW-1:0], nh};
                        len_d  = len_q + LW'(grow);
                        cur_d  = pend_q;
                        step_d = 1'b1;
                        eat_d  = eat_hit;
                    end
                end
            end
            StDead: begin
                if (start) begin
                    state_d = StRun;
                    body_d  = INIT_BODY;
                    len_d   = LW'(INIT_LEN);
                    cur_d   = DIR_LEFT;
                    pend_d  = DIR_LEFT;
                end
            end
            default: state_d = StIdle;
        endcase

        occ_d = decode_occ(body_d, len_d);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= StIdle;
            body_q  <= INIT_BODY;
            len_q   <= LW'(INIT_LEN);
            occ_q   <= INIT_OCC;
            cur_q   <= DIR_LEFT;
            pend_q  <= DIR_LEFT;
            step_q  <= 1'b0;
            eat_q   <= 1'b0;
            die_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            body_q  <= body_d;
            len_q   <= len_d;
            occ_q   <= occ_d;
            cur_q   <= cur_d;
            pend_q  <= pend_d;
            step_q  <= step_d;
            eat_q   <= eat_d;
            die_q   <= die_d;
        end
    end

    assign body       = body_q;
    assign len        = len_q;
    assign occ        = occ_q;
    assign game_state = state_q;
    assign step       = step_q;
    assign eat        = eat_q;
    assign die        = die_q;

endmodule

// File: tb/tb_snake_engine.sv
// Directed bench: instance a wraps at edges, instance b dies on a wall hit.
module tb_snake_engine;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [3:0]  dir_req = '0;
    logic        start = 1'b0;
    logic [5:0]  food_pos = '0;
    logic        food_valid = 1'b0;

    logic [47:0] body_a, body_b;
    logic [3:0]  len_a, len_b;
    logic [63:0] occ_a, occ_b;
    logic [1:0]  gs_a, gs_b;
    logic        step_a, eat_a, die_a, step_b, eat_b, die_b;

    int total = 0;
    int bad = 0;
    int cyc;

    always #5 sys_clk = ~sys_clk;

    snake_engine #(
        .GRID_W(8), .GRID_H(8), .MAX_LEN(8), .INIT_LEN(4), .TICK_CYCLES(4), .WRAP(1)
    ) dut_a (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .dir_req(dir_req), .start(start),
        .food_pos(food_pos), .food_valid(food_valid), .body(body_a), .len(len_a),
        .occ(occ_a), .game_state(gs_a), .step(step_a), .eat(eat_a), .die(die_a)
    );

    snake_engine #(
        .GRID_W(8), .GRID_H(8), .MAX_LEN(8), .INIT_LEN(4), .TICK_CYCLES(4), .WRAP(0)
    ) dut_b (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .dir_req(dir_req), .start(start),
        .food_pos(food_pos), .food_valid(food_valid), .body(body_b), .len(len_b),
        .occ(occ_b), .game_state(gs_b), .step(step_b), .eat(eat_b), .die(die_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks length, the first n segments and the occupancy implied by them.
    task automatic chk_snake(input string tag, input logic [47:0] b, input logic [3:0] l,
                             input logic [63:0] o, input int n,
                             input int e0, input int e1, input int e2, input int e3,
                             input int e4);
        int          e[5];
        logic [63:0] oexp;
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3; e[4] = e4;
        oexp = '0;
        chk({tag, "_len"}, 64'(l), 64'(n));
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_seg%0d", tag, i), 64'(b[i*6 +: 6]), 64'(e[i]));
            oexp[e[i]] = 1'b1;
        end
        chk({tag, "_occ"}, o, oexp);
    endtask

    task automatic do_reset();
        sys_rst_n  = 1'b0;
        start      = 1'b0;
        dir_req    = '0;
        food_valid = 1'b0;
        food_pos   = '0;
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
    endtask

    task automatic wait_step(input string tag, output int cycles);
        cycles = 0;
        do begin
            @(negedge sys_clk);
            cycles++;
        end while (!(step_a || die_a) && cycles < 20);
        if (cycles >= 20) chk({tag, "_timeout"}, 64'(step_a || die_a), 64'd1);
    endtask

    initial begin
        // Reset values and wrap versus wall.
        do_reset();
        chk("rst_state", 64'(gs_a), 64'd0);
        chk("rst_pulses", 64'({step_a, eat_a, die_a}), 64'd0);
        chk_snake("rst", body_a, len_a, occ_a, 4, 36, 37, 38, 39, 0);
        chk("rst_stale_slots", 64'(body_a[47:24]), 64'd0);
        chk("rst_state_b", 64'(gs_b), 64'd0);

        pulse_start();
        chk("run_state", 64'(gs_a), 64'd1);
        wait_step("s1", cyc);
        chk("first_latency", 64'(cyc), 64'd4);
        chk("s1_pulses", 64'({step_a, eat_a, die_a}), 64'b100);
        chk_snake("s1", body_a, len_a, occ_a, 4, 35, 36, 37, 38, 0);
        @(negedge sys_clk);
        chk("step_one_cycle", 64'(step_a), 64'd0);

        dir_req = 4'b1000;
        wait_step("s2", cyc);
        chk_snake("reverse1", body_a, len_a, occ_a, 4, 34, 35, 36, 37, 0);
        wait_step("s3", cyc);
        chk("step_period", 64'(cyc), 64'd4);
        chk_snake("reverse2", body_a, len_a, occ_a, 4, 33, 34, 35, 36, 0);
        dir_req = '0;
        wait_step("s4", cyc);
        chk_snake("edge_a", body_a, len_a, occ_a, 4, 32, 33, 34, 35, 0);
        chk("edge_state_b", 64'(gs_b), 64'd1);
        wait_step("s5", cyc);
        chk_snake("wrap_a", body_a, len_a, occ_a, 4, 39, 32, 33, 34, 0);
        chk("wrap_state_a", 64'(gs_a), 64'd1);
        chk("wall_state_b", 64'(gs_b), 64'd2);
        chk("wall_pulses_b", 64'({step_b, eat_b, die_b}), 64'b001);
        chk_snake("wall_frozen_b", body_b, len_b, occ_b, 4, 32, 33, 34, 35, 0);
        @(negedge sys_clk);
        chk("die_one_cycle_b", 64'(die_b), 64'd0);
        pulse_start();
        chk("start_ignored_a", 64'(gs_a), 64'd1);
        chk_snake("ignored_a", body_a, len_a, occ_a, 4, 39, 32, 33, 34, 0);
        chk("restart_state_b", 64'(gs_b), 64'd1);
        chk_snake("restart_b", body_b, len_b, occ_b, 4, 36, 37, 38, 39, 0);

        // Eat, then self-collision.
        do_reset();
        food_pos   = 6'd35;
        food_valid = 1'b1;
        pulse_start();
        wait_step("e1", cyc);
        chk("eat_pulses", 64'({step_a, eat_a, die_a}), 64'b110);
        chk_snake("eat", body_a, len_a, occ_a, 5, 35, 36, 37, 38, 39);
        food_valid = 1'b0;
        dir_req    = 4'b0001;
        @(negedge sys_clk);
        chk("eat_one_cycle", 64'(eat_a), 64'd0);
        wait_step("e2", cyc);
        chk_snake("up", body_a, len_a, occ_a, 5, 27, 35, 36, 37, 38);
        dir_req = 4'b1000;
        wait_step("e3", cyc);
        chk_snake("right", body_a, len_a, occ_a, 5, 28, 27, 35, 36, 37);
        dir_req = 4'b0010;
        wait_step("e4", cyc);
        chk("self_state", 64'(gs_a), 64'd2);
        chk("self_pulses", 64'({step_a, eat_a, die_a}), 64'b001);
        chk_snake("self_frozen", body_a, len_a, occ_a, 5, 28, 27, 35, 36, 37);
        dir_req = '0;
        @(negedge sys_clk);
        pulse_start();
        chk("reinit_state", 64'(gs_a), 64'd1);
        chk_snake("reinit", body_a, len_a, occ_a, 4, 36, 37, 38, 39, 0);

        // Tail chase: the head may enter the cell the tail vacates.
        do_reset();
        dir_req = 4'b0001;
        @(negedge sys_clk);
        pulse_start();
        wait_step("t1", cyc);
        chk_snake("idle_req", body_a, len_a, occ_a, 4, 28, 36, 37, 38, 0);
        dir_req = 4'b1000;
        wait_step("t2", cyc);
        chk_snake("chase1", body_a, len_a, occ_a, 4, 29, 28, 36, 37, 0);
        dir_req = 4'b0010;
        wait_step("t3", cyc);
        chk("chase_pulses", 64'({step_a, eat_a, die_a}), 64'b100);
        chk("chase_state", 64'(gs_a), 64'd1);
        chk_snake("chase", body_a, len_a, occ_a, 4, 37, 29, 28, 36, 0);

        // Grow to MAX_LEN; eating at full length keeps len and frees the tail.
        do_reset();
        food_valid = 1'b1;
        food_pos   = 6'd35;
        pulse_start();
        for (int k = 0; k < 4; k++) begin
            wait_step("g", cyc);
            chk($sformatf("grow%0d_len", k), 64'(len_a), 64'(5 + k));
            chk($sformatf("grow%0d_eat", k), 64'(eat_a), 64'd1);
            food_pos = 6'(34 - k);
        end
        food_pos = 6'd39;
        wait_step("gmax", cyc);
        chk("max_pulses", 64'({step_a, eat_a, die_a}), 64'b110);
        chk("max_len", 64'(len_a), 64'd8);
        chk("max_head", 64'(body_a[5:0]), 64'd39);
        chk("max_occ", occ_a, 64'h0000_00FF_0000_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
